// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word type, next-PC select and fetch state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Width of the sequential PC increment operand.
    localparam int unsigned PC_STEP_W = 32;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JR,
        SEL_JMP,
        SEL_HOLD
    } fetch_sel_t;

    typedef enum logic {
        FS_RUN,
        FS_HALT
    } fetch_state_t;

    // Redirect targets are forced onto a word boundary.
    function automatic word_t align_word(input word_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: imem request/response, hazard/redirect inputs, IF/ID outputs.
// Optional FETCH_PERF_EN adds the performance counter outputs.
interface fetch_stage_if;
    import cpu_types_pkg::*;

    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t imemaddr;
    logic  stall_i;
    logic  halt_i;
    logic  redir_br_i;
    word_t br_target_i;
    logic  redir_jmp_i;
    word_t jmp_target_i;
    logic  redir_jr_i;
    word_t jr_target_i;
    word_t instr_o;
    word_t npc_o;
    logic  valid_o;
    logic  halted_o;
`ifdef FETCH_PERF_EN
    word_t perf_fetch_o;
    word_t perf_stall_o;
    word_t perf_flush_o;
`endif

    modport fs (
        input  ihit, imemload, stall_i, halt_i,
        input  redir_br_i, br_target_i, redir_jmp_i, jmp_target_i,
        input  redir_jr_i, jr_target_i,
        output iREN, imemaddr, instr_o, npc_o, valid_o, halted_o
`ifdef FETCH_PERF_EN
        , output perf_fetch_o, perf_stall_o, perf_flush_o
`endif
    );

    modport tb (
        output ihit, imemload, stall_i, halt_i,
        output redir_br_i, br_target_i, redir_jmp_i, jmp_target_i,
        output redir_jr_i, jr_target_i,
        input  iREN, imemaddr, instr_o, npc_o, valid_o, halted_o
`ifdef FETCH_PERF_EN
        , input perf_fetch_o, perf_stall_o, perf_flush_o
`endif
    );

endinterface

// File: rtl/if_id_reg.sv
// Pipeline latch with load / bubble / hold controls.
// The clr payload is zeroed by a bubble; the keep payload holds through a bubble.
module if_id_reg #(
    parameter int unsigned CLR_W  = 32,
    parameter int unsigned KEEP_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  logic [CLR_W-1:0]  clr_d,
    input  logic [KEEP_W-1:0] keep_d,
    output logic [CLR_W-1:0]  clr_q,
    output logic [KEEP_W-1:0] keep_q,
    output logic              valid_q
);

    // Bubble wins over load; neither asserted means hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q   <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else if (bubble) begin
            clr_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            clr_q   <= clr_d;
            keep_q  <= keep_d;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request, redirects (br > jr > jmp), sticky halt,
// IF/ID latch. Optional macro FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t                 PC_INIT = 32'h0000_0000,
    parameter logic [PC_STEP_W-1:0] PC_STEP = 32'd4
) (
    input logic      CLK,
    input logic      nRST,
    fetch_stage_if.fs fif
);

    fetch_state_t state, state_next;
    fetch_sel_t   sel;
    word_t        pc, pc_next, pc_seq;
    logic         load, bubble;
    logic         rule_fetch, rule_stall, rule_flush;
    word_t        instr_q, npc_q;
    logic         valid_q;

    assign pc_seq       = pc + PC_STEP;
    assign fif.iREN     = (state != FS_HALT);
    assign fif.imemaddr = pc;
    assign fif.halted_o = (state == FS_HALT);
    assign fif.instr_o  = instr_q;
    assign fif.npc_o    = npc_q;
    assign fif.valid_o  = valid_q;

    // Halt state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= FS_RUN;
        else       state <= state_next;
    end

    // Edge-action priority: halted, redirect, halt_i, stall, hit, miss.
    always_comb begin
        state_next = state;
        sel        = SEL_HOLD;
        load       = 1'b0;
        bubble     = 1'b0;
        rule_fetch = 1'b0;
        rule_stall = 1'b0;
        rule_flush = 1'b0;
        if (state == FS_HALT) begin
            bubble = 1'b1;
        end else if (fif.redir_br_i) begin
            sel = SEL_BR;  bubble = 1'b1; rule_flush = 1'b1;
        end else if (fif.redir_jr_i) begin
            sel = SEL_JR;  bubble = 1'b1; rule_flush = 1'b1;
        end else if (fif.redir_jmp_i) begin
            sel = SEL_JMP; bubble = 1'b1; rule_flush = 1'b1;
        end else if (fif.halt_i) begin
            state_next = FS_HALT;
            bubble     = 1'b1;
        end else if (fif.stall_i) begin
            rule_stall = 1'b1;
        end else if (fif.ihit) begin
            sel = SEL_SEQ; load = 1'b1; rule_fetch = 1'b1;
        end else begin
            bubble = 1'b1; rule_stall = 1'b1;
        end
    end

    // Next-PC mux.
    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_SEQ: pc_next = pc_seq;
            SEL_BR:  pc_next = align_word(fif.br_target_i);
            SEL_JR:  pc_next = align_word(fif.jr_target_i);
            SEL_JMP: pc_next = align_word(fif.jmp_target_i);
            default: pc_next = pc;
        endcase
    end

    // PC register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) pc <= PC_INIT;
        else       pc <= pc_next;
    end

    if_id_reg #(.CLR_W(32), .KEEP_W(32)) u_if_id (
        .clk     (CLK),
        .rst_n   (nRST),
        .load    (load),
        .bubble  (bubble),
        .clr_d   (fif.imemload),
        .keep_d  (pc_seq),
        .clr_q   (instr_q),
        .keep_q  (npc_q),
        .valid_q (valid_q)
    );

`ifdef FETCH_PERF_EN
    word_t cnt_fetch, cnt_stall, cnt_flush;

    assign fif.perf_fetch_o = cnt_fetch;
    assign fif.perf_stall_o = cnt_stall;
    assign fif.perf_flush_o = cnt_flush;

    // Saturating event counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_fetch <= '0;
            cnt_stall <= '0;
            cnt_flush <= '0;
        end else begin
            if (rule_fetch && cnt_fetch != '1) cnt_fetch <= cnt_fetch + 32'd1;
            if (rule_stall && cnt_stall != '1) cnt_stall <= cnt_stall + 32'd1;
            if (rule_flush && cnt_flush != '1) cnt_flush <= cnt_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes expected IF state per edge,
// a monitor pops and compares after each rising edge.
module tb_fetch_stage;
    import cpu_types_pkg::*;

    typedef struct {
        string name;
        word_t pc;
        word_t instr;
        word_t npc;
        logic  valid;
        logic  halted;
    } exp_t;

    logic clk;
    logic nrst;
    exp_t q[$];
    int   checks;
    int   errors;

    fetch_stage_if fif();

    fetch_stage dut (
        .CLK  (clk),
        .nRST (nrst),
        .fif  (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input word_t act, input word_t want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s.%s: got %h, want %h", nm, fld, act, want);
        end
    endtask

    // Monitor: compare the DUT against the oldest pending expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "imemaddr", fif.imemaddr, e.pc);
                chk(e.name, "iREN", {31'd0, fif.iREN}, {31'd0, ~e.halted});
                chk(e.name, "instr_o", fif.instr_o, e.instr);
                chk(e.name, "npc_o", fif.npc_o, e.npc);
                chk(e.name, "valid_o", {31'd0, fif.valid_o}, {31'd0, e.valid});
                chk(e.name, "halted_o", {31'd0, fif.halted_o}, {31'd0, e.halted});
            end
        end
    end

    // Apply one cycle of inputs at the falling edge and queue the post-edge expectation.
    task automatic step(input string nm, input logic rst, input logic ih, input word_t im,
                        input logic st, input logic hl,
                        input logic br, input word_t brt, input logic jr, input word_t jrt,
                        input logic jp, input word_t jpt,
                        input word_t e_pc, input word_t e_instr, input word_t e_npc,
                        input logic e_v, input logic e_h);
        exp_t e;
        @(negedge clk);
        nrst             = rst;
        fif.ihit         = ih;
        fif.imemload     = im;
        fif.stall_i      = st;
        fif.halt_i       = hl;
        fif.redir_br_i   = br;
        fif.br_target_i  = brt;
        fif.redir_jr_i   = jr;
        fif.jr_target_i  = jrt;
        fif.redir_jmp_i  = jp;
        fif.jmp_target_i = jpt;
        e.name = nm; e.pc = e_pc; e.instr = e_instr; e.npc = e_npc;
        e.valid = e_v; e.halted = e_h;
        q.push_back(e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nrst = 1'b0;
        fif.ihit = 1'b0; fif.imemload = '0; fif.stall_i = 1'b0; fif.halt_i = 1'b0;
        fif.redir_br_i = 1'b0; fif.br_target_i = '0;
        fif.redir_jr_i = 1'b0; fif.jr_target_i = '0;
        fif.redir_jmp_i = 1'b0; fif.jmp_target_i = '0;

        //        name          rst ih imemload      st hl br brt        jr jrt        jp jpt           pc            instr         npc           v  h
        step("reset",        0, 1, 32'h2001_0005, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0);
        step("idle",         1, 0, 32'h0,         0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0);
        step("fetch0",       1, 1, 32'h2001_0005, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h4,        32'h2001_0005, 32'h4,       1, 0);
        step("miss",         1, 0, 32'hFFFF_0000, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h4,        32'h0,        32'h4,        0, 0);
        step("fetch1",       1, 1, 32'h8C22_0000, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h8,        32'h8C22_0000, 32'h8,       1, 0);
        step("stall",        1, 1, 32'hDEAD_BEEF, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h8,        32'h8C22_0000, 32'h8,       1, 0);
        step("br_over_jmp",  1, 1, 32'h1111_1111, 0, 0, 1, 32'h40,    0, 32'h0,     1, 32'h100,       32'h40,       32'h0,        32'h8,        0, 0);
        step("fetch2",       1, 1, 32'h0000_0020, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h44,       32'h0000_0020, 32'h44,      1, 0);
        step("jr_over_jmp",  1, 1, 32'h2222_2222, 1, 0, 0, 32'h0,     1, 32'h103,   1, 32'h200,       32'h100,      32'h0,        32'h44,       0, 0);
        step("jmp_align",    1, 0, 32'h0,         0, 0, 0, 32'h0,     0, 32'h0,     1, 32'h1FF,       32'h1FC,      32'h0,        32'h44,       0, 0);
        step("jmp_top",      1, 0, 32'h0,         0, 0, 0, 32'h0,     0, 32'h0,     1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,       32'h44,       0, 0);
        step("wrap",         1, 1, 32'h1234_5678, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h0,        32'h1234_5678, 32'h0,       1, 0);
        step("halt_squash",  1, 1, 32'hAAAA_AAAA, 0, 1, 1, 32'h80,    0, 32'h0,     0, 32'h0,         32'h80,       32'h0,        32'h0,        0, 0);
        step("jmp20",        1, 0, 32'h0,         0, 0, 0, 32'h0,     0, 32'h0,     1, 32'h20,        32'h20,       32'h0,        32'h0,        0, 0);
        step("halt",         1, 1, 32'h5555_5555, 0, 1, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h20,       32'h0,        32'h0,        0, 1);
        for (int unsigned i = 0; i < 10; i++) begin
            step("halted_hold", 1, 1, 32'h6666_0000 + i, i[1], 0, i[0], 32'h300, 0, 32'h0, 0, 32'h0,  32'h20,       32'h0,        32'h0,        0, 1);
        end
        step("reset2",       0, 1, 32'h7777_7777, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h0,        32'h0,        32'h0,        0, 0);
        step("pf_fetch_a",   1, 1, 32'hA000_0001, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h4,        32'hA000_0001, 32'h4,       1, 0);
        step("pf_fetch_b",   1, 1, 32'hB000_0002, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'h8,        32'hB000_0002, 32'h8,       1, 0);
        step("pf_fetch_c",   1, 1, 32'hC000_0003, 0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'hC,        32'hC000_0003, 32'hC,       1, 0);
        step("pf_stall",     1, 1, 32'hD000_0004, 1, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'hC,        32'hC000_0003, 32'hC,       1, 0);
        step("pf_miss",      1, 0, 32'h0,         0, 0, 0, 32'h0,     0, 32'h0,     0, 32'h0,         32'hC,        32'h0,        32'hC,        0, 0);
        step("pf_flush",     1, 0, 32'h0,         0, 0, 0, 32'h0,     0, 32'h0,     1, 32'h40,        32'h40,       32'h0,        32'hC,        0, 0);

        @(posedge clk);
        #2;
`ifdef FETCH_PERF_EN
        chk("perf", "fetch", fif.perf_fetch_o, 32'd3);
        chk("perf", "stall", fif.perf_stall_o, 32'd2);
        chk("perf", "flush", fif.perf_flush_o, 32'd1);
`endif
        chk("drain", "pending", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
